// File: rtl/arcade_input_mapper_if.sv
// rtl/arcade_input_mapper_if.sv - ioctl download bus between hps_io and the input mapper
interface arcade_input_mapper_if;
  logic        wr;
  logic [7:0]  index;
  logic [24:0] addr;
  logic [7:0]  dout;

  modport master (output wr, index, addr, dout);
  modport slave  (input  wr, index, addr, dout);
endinterface

// File: rtl/arcade_input_mapper.sv
// rtl/arcade_input_mapper.sv - PS/2 + joystick to active-low INP/DSW bytes, coin pulses, DIP capture
// Optional autofire on joystick bit 10 is enabled by defining INPUT_AUTOFIRE_EN.
module arcade_input_mapper #(
  parameter int NPLAYERS   = 2,
  parameter int DSW_BYTES  = 8,
  parameter int COIN_PULSE = 480000,
  parameter int COIN_SPLIT = 0
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic [10:0]            ps2_key,
  input  logic [16*NPLAYERS-1:0] joystick,
  input  logic                   cocktail,
  arcade_input_mapper_if.slave   ioctl,
  output logic [8*NPLAYERS-1:0]  inp_player,
  output logic [7:0]             inp_sys,
  output logic [8*DSW_BYTES-1:0] dsw,
  output logic [7:0]             sysmode
);

  localparam int CW = $clog2(COIN_PULSE + 1);
  localparam int NK = 18;

  typedef enum logic [1:0] {IDLE, PULSE, WAIT} coin_state_t;

  // Key slots 0..6 / 7..13 follow the joystick bit order {B3,B2,B1,U,D,L,R} for P1 / P2;
  // 14 start1, 15 start2, 16 coin1, 17 coin2.
  function automatic logic [NK-1:0] key_decode(input logic [8:0] code);
    logic [NK-1:0] m;
    m = '0;
    case (code[7:0])
      8'h74:   m[0] = 1'b1;
      8'h6B:   m[1] = 1'b1;
      8'h72:   m[2] = 1'b1;
      8'h75:   m[3] = 1'b1;
      default: ;
    endcase
    if (!code[8]) begin
      case (code[7:0])
        8'h29:   m[4]  = 1'b1;
        8'h14:   m[5]  = 1'b1;
        8'h11:   m[6]  = 1'b1;
        8'h34:   m[7]  = 1'b1;
        8'h23:   m[8]  = 1'b1;
        8'h2B:   m[9]  = 1'b1;
        8'h2D:   m[10] = 1'b1;
        8'h1C:   m[11] = 1'b1;
        8'h1B:   m[12] = 1'b1;
        8'h15:   m[13] = 1'b1;
        8'h16:   m[14] = 1'b1;
        8'h1E:   m[15] = 1'b1;
        8'h05:   begin m[14] = 1'b1; m[16] = 1'b1; end
        8'h06:   begin m[15] = 1'b1; m[17] = 1'b1; end
        8'h2E:   m[16] = 1'b1;
        8'h36:   m[17] = 1'b1;
        default: ;
      endcase
    end
    return m;
  endfunction

  logic          ps2_tog;
  logic [NK-1:0] key_state;
  logic [NK-1:0] key_hit;
  logic          ps2_event;

  assign key_hit   = key_decode(ps2_key[8:0]);
  assign ps2_event = ps2_key[10] != ps2_tog;

  always_ff @(posedge clk_sys) begin
    ps2_tog <= ps2_key[10];
    if (reset) begin
      key_state <= '0;
    end else if (ps2_event) begin
      key_state <= ps2_key[9] ? (key_state | key_hit) : (key_state & ~key_hit);
    end
  end

  logic fire_phase;
`ifdef INPUT_AUTOFIRE_EN
  logic [17:0] af_div;
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      af_div     <= '0;
      fire_phase <= 1'b0;
    end else begin
      af_div <= af_div + 18'd1;
      if (&af_div) fire_phase <= ~fire_phase;
    end
  end
`else
  assign fire_phase = 1'b1;
`endif

  logic [6:0]          key_p [2];
  logic [6:0]          src   [NPLAYERS];
  logic [6:0]          eff   [NPLAYERS];
  logic [NPLAYERS-1:0] coin_src;
  logic                start1, start2;
  logic                unused_bits;

  assign key_p[0] = key_state[6:0];
  assign key_p[1] = key_state[13:7];

  always_comb begin
    start1      = key_state[14];
    start2      = key_state[15];
    unused_bits = 1'b0;
    for (int p = 0; p < NPLAYERS; p++) begin
      src[p]      = joystick[16*p +: 7] | ((p < 2) ? key_p[p[0]] : 7'd0);
      coin_src[p] = joystick[16*p+9] | ((p == 0) ? key_state[16] : (p == 1) ? key_state[17] : 1'b0);
      start1      = start1 | joystick[16*p+7];
      start2      = start2 | joystick[16*p+8];
      unused_bits = unused_bits ^ (^joystick[16*p+11 +: 5]) ^ fire_phase;
`ifndef INPUT_AUTOFIRE_EN
      unused_bits = unused_bits ^ joystick[16*p+10];
`endif
    end
    for (int p = 0; p < NPLAYERS; p++) begin
      eff[p] = src[p];
      if (p == 0 && !cocktail) eff[p] = src[0] | src[1];
`ifdef INPUT_AUTOFIRE_EN
      eff[p][4] = eff[p][4] & (~joystick[16*p+10] | fire_phase);
`endif
    end
  end

  coin_state_t   coin_state [NPLAYERS];
  coin_state_t   coin_next  [NPLAYERS];
  logic [CW-1:0] coin_cnt      [NPLAYERS];
  logic [CW-1:0] coin_cnt_next [NPLAYERS];

  always_ff @(posedge clk_sys) begin
    for (int p = 0; p < NPLAYERS; p++) begin
      if (reset) begin
        coin_state[p] <= IDLE;
        coin_cnt[p]   <= '0;
      end else begin
        coin_state[p] <= coin_next[p];
        coin_cnt[p]   <= coin_cnt_next[p];
      end
    end
  end

  // WAIT holds off a new pulse until the source has been released.
  always_comb begin
    for (int p = 0; p < NPLAYERS; p++) begin
      coin_next[p]     = coin_state[p];
      coin_cnt_next[p] = coin_cnt[p];
      case (coin_state[p])
        IDLE: if (coin_src[p]) begin
          coin_next[p]     = PULSE;
          coin_cnt_next[p] = CW'(COIN_PULSE - 1);
        end
        PULSE: if (coin_cnt[p] == '0) coin_next[p] = WAIT;
               else coin_cnt_next[p] = coin_cnt[p] - CW'(1);
        WAIT: if (!coin_src[p]) coin_next[p] = IDLE;
        default: coin_next[p] = IDLE;
      endcase
    end
  end

  logic [8*NPLAYERS-1:0] player_n;
  logic [7:0]            sys_n;
  logic [3:0]            coin_on;

  always_comb begin
    coin_on = '0;
    for (int p = 0; p < NPLAYERS; p++) begin
      player_n[8*p +: 8] = ~{eff[p][1], eff[p][0], eff[p][3], eff[p][2],
                             1'b0, eff[p][5], eff[p][4], eff[p][6]};
      coin_on[p] = coin_state[p] == PULSE;
    end
    if (COIN_SPLIT != 0) sys_n = ~{2'b00, start2, start1, coin_on};
    else                 sys_n = ~{2'b00, start2, start1, 3'b000, |coin_on};
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      inp_player <= '1;
      inp_sys    <= 8'hFF;
    end else begin
      inp_player <= player_n;
      inp_sys    <= sys_n;
    end
  end

  // Config bytes live across user resets, so capture ignores reset.
  logic [8*DSW_BYTES-1:0] dsw_r     = '0;
  logic [7:0]             sysmode_r = 8'h00;

  always_ff @(posedge clk_sys) begin
    if (ioctl.wr && ioctl.index == 8'd1 && ioctl.addr == 25'd0) sysmode_r <= ioctl.dout;
    for (int k = 0; k < DSW_BYTES; k++) begin
      if (ioctl.wr && ioctl.index == 8'd254 && ioctl.addr == 25'(k)) dsw_r[8*k +: 8] <= ioctl.dout;
    end
  end

  assign dsw     = dsw_r;
  assign sysmode = sysmode_r;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb/tb_arcade_input_mapper.sv - scoreboard bench for arcade_input_mapper (2 players, 4-cycle coin)
module tb_arcade_input_mapper;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [31:0] joystick;
  logic        cocktail;
  logic [15:0] inp_player;
  logic [7:0]  inp_sys;
  logic [63:0] dsw;
  logic [7:0]  sysmode;

  arcade_input_mapper_if ioctl ();

  arcade_input_mapper #(
    .NPLAYERS(2), .DSW_BYTES(8), .COIN_PULSE(4), .COIN_SPLIT(0)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .joystick(joystick),
    .cocktail(cocktail), .ioctl(ioctl), .inp_player(inp_player), .inp_sys(inp_sys),
    .dsw(dsw), .sysmode(sysmode)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   coin_low;
  int   coin_pulses;

  function automatic logic [63:0] observe(input int sel);
    case (sel)
      0:       return {48'd0, inp_player};
      1:       return {56'd0, inp_sys};
      2:       return dsw;
      3:       return {56'd0, sysmode};
      4:       return 64'(coin_low);
      default: return 64'(coin_pulses);
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [63:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t        e;
    logic [63:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      compared++;
      assert (obs === e.exp) else begin
        mismatched++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic ps2(input logic pressed, input logic [8:0] code);
    ps2_key = {~ps2_key[10], pressed, code};
  endtask

  task automatic ioctl_write(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    ioctl.wr    = 1'b1;
    ioctl.index = idx;
    ioctl.addr  = a;
    ioctl.dout  = d;
    tick(1);
    ioctl.wr = 1'b0;
  endtask

  // Source must already be asserted; it is released after `hold` samples.
  task automatic coin_window(input bit by_key, input logic [8:0] code, input int hold, input int total);
    logic prev;
    prev        = 1'b1;
    coin_low    = 0;
    coin_pulses = 0;
    for (int i = 0; i < total; i++) begin
      if (i == hold) begin
        if (by_key) ps2(1'b0, code);
        else        joystick[9] = 1'b0;
      end
      tick(1);
      if (!inp_sys[0]) coin_low++;
      if (prev && !inp_sys[0]) coin_pulses++;
      prev = inp_sys[0];
    end
  endtask

  initial begin
    reset       = 1'b1;
    ps2_key     = '0;
    joystick    = '0;
    cocktail    = 1'b0;
    ioctl.wr    = 1'b0;
    ioctl.index = '0;
    ioctl.addr  = '0;
    ioctl.dout  = '0;

    expect_val("reset_player", 0, 64'hFFFF);
    expect_val("reset_sys", 1, 64'hFF);
    expect_val("dsw_powerup", 2, 64'h0);
    expect_val("sysmode_powerup", 3, 64'h0);
    tick(3);
    check_sb();

    ps2_key = {1'b1, 1'b1, 9'h029};
    tick(1);
    reset = 1'b0;
    expect_val("no_spurious_event", 0, 64'hFFFF);
    tick(3);
    check_sb();

    ps2(1'b1, 9'h029);
    expect_val("ps2_b1_one_cycle", 0, 64'hFFFF);
    tick(1);
    check_sb();
    expect_val("ps2_b1_press", 0, 64'hFFFD);
    tick(1);
    check_sb();
    ps2(1'b0, 9'h029);
    expect_val("ps2_b1_release", 0, 64'hFFFF);
    tick(2);
    check_sb();

    ps2(1'b1, 9'h175);
    expect_val("ps2_ext_up", 0, 64'hFFDF);
    tick(2);
    check_sb();
    ps2(1'b0, 9'h175);
    tick(2);

    ps2(1'b1, 9'h01C);
    expect_val("ps2_p2_b1_merged", 0, 64'hFDFD);
    tick(2);
    check_sb();
    ps2(1'b0, 9'h01C);
    tick(2);

    ps2(1'b1, 9'h05A);
    expect_val("ps2_unmapped", 0, 64'hFFFF);
    tick(2);
    check_sb();
    ps2(1'b0, 9'h05A);
    tick(2);

    joystick[19] = 1'b1;
    expect_val("joy_p2_up_merged", 0, 64'hDFDF);
    tick(1);
    check_sb();
    cocktail = 1'b1;
    expect_val("joy_p2_up_cocktail", 0, 64'hDFFF);
    tick(1);
    check_sb();
    joystick = '0;
    cocktail = 1'b0;

    joystick[6:0] = 7'h41;
    expect_val("joy_p1_r_b3", 0, 64'hFFBE);
    tick(1);
    check_sb();
    joystick[6:0] = 7'h22;
    expect_val("joy_p1_l_b2", 0, 64'hFF7B);
    tick(1);
    check_sb();
    joystick = '0;

    joystick[4] = 1'b1;
    ps2(1'b1, 9'h029);
    tick(2);
    ps2(1'b0, 9'h029);
    expect_val("or_key_release_joy_held", 0, 64'hFFFD);
    tick(2);
    check_sb();
    joystick = '0;
    tick(1);

    joystick[23] = 1'b1;
    expect_val("p2_start1", 1, 64'hEF);
    tick(1);
    check_sb();
    ps2(1'b1, 9'h01E);
    expect_val("both_starts", 1, 64'hCF);
    tick(2);
    check_sb();
    ps2(1'b0, 9'h01E);
    joystick = '0;
    expect_val("starts_released", 1, 64'hFF);
    tick(2);
    check_sb();

    joystick[9] = 1'b1;
    expect_val("joy_coin_width", 4, 64'd4);
    expect_val("joy_coin_count", 5, 64'd1);
    coin_window(1'b0, 9'h000, 20, 26);
    check_sb();

    ps2(1'b1, 9'h036);
    expect_val("key_coin2_width", 4, 64'd4);
    expect_val("key_coin2_count", 5, 64'd1);
    coin_window(1'b1, 9'h036, 20, 26);
    check_sb();

    for (int a = 0; a < 10; a++) ioctl_write(8'd254, 25'(a), 8'hA0 + 8'(a));
    ioctl_write(8'd1, 25'd0, 8'h05);
    expect_val("dsw_capture", 2, 64'hA7A6A5A4A3A2A1A0);
    expect_val("sysmode_capture", 3, 64'h05);
    check_sb();
    ioctl_write(8'd2, 25'd0, 8'h77);
    ioctl_write(8'd1, 25'd1, 8'h66);
    expect_val("sysmode_other_ignored", 3, 64'h05);
    check_sb();

    reset = 1'b1;
    ioctl_write(8'd1, 25'd0, 8'h5A);
    tick(2);
    expect_val("sysmode_capture_in_reset", 3, 64'h5A);
    expect_val("dsw_survives_reset", 2, 64'hA7A6A5A4A3A2A1A0);
    expect_val("player_in_reset", 0, 64'hFFFF);
    check_sb();
    reset = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
